rm_lane_retire: RTL and testbench

- Commit-side counterpart of the runtime-monitor lane allocator in the ID stage.
- The allocator tags decoded instructions with a monitor lane. This block tracks each lane from allocation through commit and a fixed monitor-check latency.
- It then returns the lane to the allocator by emitting per-event release (reset_monitor) pulses.
- It also force-releases lanes orphaned by a pipeline flush or stuck past a timeout, and counts those abnormal releases.

---
 rtl/rm_lane_retire.sv | 139 +++++++++++++
 tb/tb_rm_lane_retire.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/rm_lane_retire.sv
// Commit-side lane tracker for the runtime monitor: follows each lane from
// allocation through commit and monitor check, then returns it via release pulses.
module rm_lane_retire #(
    parameter int NUM_LANES  = 4,
    parameter int NUM_EVENTS = 2,
    parameter int LANE_W     = $clog2(NUM_LANES),
    parameter int EVT_W      = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1,
    parameter int CHECK_LAT  = 3,
    parameter int TIMEOUT    = 64
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         alloc_valid_i,
    input  logic [LANE_W-1:0]            alloc_lane_i,
    input  logic [EVT_W-1:0]             alloc_event_i,
    input  logic                         commit_valid_i,
    input  logic [LANE_W-1:0]            commit_lane_i,
    output logic [NUM_EVENTS-1:0]        reset_valid_o,
    output logic [NUM_EVENTS*LANE_W-1:0] reset_lane_o,
    output logic [NUM_LANES-1:0]         lane_busy_o,
    output logic [15:0]                  orphan_cnt_o,
    output logic                         protocol_err_o
);

    localparam int TMR_MAX = (TIMEOUT > CHECK_LAT) ? TIMEOUT : CHECK_LAT;
    localparam int TMR_W   = ($clog2(TMR_MAX + 1) > 7) ? $clog2(TMR_MAX + 1) : 7;
    localparam int ORPH_W  = $clog2(NUM_LANES + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY    = 2'd1;
    localparam logic [1:0] ST_CHECK   = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    logic [1:0]       state_q [NUM_LANES];
    logic [EVT_W-1:0] event_q [NUM_LANES];
    logic [TMR_W-1:0] timer_q [NUM_LANES];
    logic [NUM_LANES-1:0] orphan_q;

    logic [NUM_EVENTS-1:0] grant_valid;
    logic [LANE_W-1:0]     grant_lane [NUM_EVENTS];
    logic [NUM_LANES-1:0]  granted;
    logic [ORPH_W-1:0]     orphan_inc;
    logic [16:0]           orphan_sum;
    logic                  alloc_err;
    logic                  commit_err;

    // One release slot per event class: the lowest-index waiting lane wins it.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        granted    = '0;
        orphan_inc = '0;
        for (int e = 0; e < NUM_EVENTS; e++) begin
            grant_valid[e] = 1'b0;
            grant_lane[e]  = '0;
            for (int l = 0; l < NUM_LANES; l++) begin
                if (!grant_valid[e] && state_q[l] == ST_RELEASE &&
                    event_q[l] == EVT_W'(e)) begin
                    grant_valid[e] = 1'b1;
                    grant_lane[e]  = LANE_W'(l);
                    granted[l]     = 1'b1;
                end
            end
        end
        for (int l = 0; l < NUM_LANES; l++) begin
            if (granted[l] && orphan_q[l]) orphan_inc = orphan_inc + ORPH_W'(1);
        end
        orphan_sum = {1'b0, orphan_cnt_o} + 17'(orphan_inc);
        alloc_err  = alloc_valid_i && (state_q[alloc_lane_i] != ST_IDLE);
        commit_err = commit_valid_i && (state_q[commit_lane_i] != ST_BUSY);
        for (int l = 0; l < NUM_LANES; l++) lane_busy_o[l] = (state_q[l] != ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only; the per-lane
    // registers are control state, so they are all reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                state_q[l] <= ST_IDLE;
                event_q[l] <= '0;
                timer_q[l] <= '0;
            end
            orphan_q <= '0;
        end else begin
            for (int l = 0; l < NUM_LANES; l++) begin
                case (state_q[l])
                    ST_IDLE: begin
                        if (alloc_valid_i && alloc_lane_i == LANE_W'(l)) begin
                            state_q[l]  <= ST_BUSY;
                            event_q[l]  <= alloc_event_i;
                            timer_q[l]  <= '0;
                            orphan_q[l] <= 1'b0;
                        end
                    end
                    ST_BUSY: begin
                        // Commit wins over flush, flush over timeout.
                        if (commit_valid_i && commit_lane_i == LANE_W'(l)) begin
                            state_q[l] <= ST_CHECK;
                            timer_q[l] <= '0;
                        end else if (flush_i || timer_q[l] == TMR_W'(TIMEOUT - 2)) begin
                            state_q[l]  <= ST_RELEASE;
                            orphan_q[l] <= 1'b1;
                        end else begin
                            timer_q[l] <= timer_q[l] + TMR_W'(1);
                        end
                    end
                    ST_CHECK: begin
                        if (timer_q[l] == TMR_W'(CHECK_LAT - 1)) begin
                            state_q[l] <= ST_RELEASE;
                            timer_q[l] <= '0;
                        end else begin
                            timer_q[l] <= timer_q[l] + TMR_W'(1);
                        end
                    end
                    default: begin
                        if (granted[l]) state_q[l] <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reset_valid_o  <= '0;
            reset_lane_o   <= '0;
            orphan_cnt_o   <= '0;
            protocol_err_o <= 1'b0;
        end else begin
            reset_valid_o <= grant_valid;
            for (int e = 0; e < NUM_EVENTS; e++) begin
                reset_lane_o[e*LANE_W +: LANE_W] <= grant_lane[e];
            end
            orphan_cnt_o <= orphan_sum[16] ? 16'hFFFF : orphan_sum[15:0];
            if (alloc_err || commit_err) protocol_err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rm_lane_retire.sv
// Directed bench for rm_lane_retire: per-cycle vector table plus hand-written
// timeout and asynchronous-reset sequences.
module tb_rm_lane_retire;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i = 1'b0;
    logic        alloc_valid_i = 1'b0;
    logic [1:0]  alloc_lane_i = '0;
    logic        alloc_event_i = 1'b0;
    logic        commit_valid_i = 1'b0;
    logic [1:0]  commit_lane_i = '0;
    logic [1:0]  reset_valid_o;
    logic [3:0]  reset_lane_o;
    logic [3:0]  lane_busy_o;
    logic [15:0] orphan_cnt_o;
    logic        protocol_err_o;

    int checks = 0;
    int errors = 0;

    rm_lane_retire dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .flush_i       (flush_i),
        .alloc_valid_i (alloc_valid_i),
        .alloc_lane_i  (alloc_lane_i),
        .alloc_event_i (alloc_event_i),
        .commit_valid_i(commit_valid_i),
        .commit_lane_i (commit_lane_i),
        .reset_valid_o (reset_valid_o),
        .reset_lane_o  (reset_lane_o),
        .lane_busy_o   (lane_busy_o),
        .orphan_cnt_o  (orphan_cnt_o),
        .protocol_err_o(protocol_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rst;
        logic        flush;
        logic        av;
        logic [1:0]  al;
        logic        ae;
        logic        cv;
        logic [1:0]  cl;
        logic [1:0]  rv;
        logic [3:0]  rl;
        logic [3:0]  busy;
        logic [15:0] orph;
        logic        perr;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic rst, logic flush, logic av, logic [1:0] al, logic ae,
                                logic cv, logic [1:0] cl, logic [1:0] rv, logic [3:0] rl,
                                logic [3:0] busy, logic [15:0] orph, logic perr);
        vec_t v;
        v.rst = rst; v.flush = flush; v.av = av; v.al = al; v.ae = ae;
        v.cv = cv; v.cl = cl; v.rv = rv; v.rl = rl; v.busy = busy;
        v.orph = orph; v.perr = perr;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        flush_i = 1'b0; alloc_valid_i = 1'b0; alloc_lane_i = '0; alloc_event_i = 1'b0;
        commit_valid_i = 1'b0; commit_lane_i = '0;
    endtask

    // Called just after a falling edge; reset released well before the next rising edge.
    task automatic do_reset();
        drive_idle();
        rst_ni = 1'b0;
        #2;
        rst_ni = 1'b1;
    endtask

    initial begin
        // Test 1: normal flow, lane 2 event 1, commit at cycle 5 -> pulse at cycle 10.
        add(1,0,1,2,1,0,0, 2'b00,4'h0,4'b0000,0,0);
        for (int k = 0; k < 4; k++) add(0,0,0,0,0,0,0, 2'b00,4'h0,4'b0100,0,0);
        add(0,0,0,0,0,1,2, 2'b00,4'h0,4'b0100,0,0);
        for (int k = 0; k < 4; k++) add(0,0,0,0,0,0,0, 2'b00,4'h0,4'b0100,0,0);
        add(0,0,0,0,0,0,0, 2'b10,4'h8,4'b0000,0,0);
        add(0,0,0,0,0,0,0, 2'b00,4'h0,4'b0000,0,0);
        // Test 2: flush orphans lane 1 while lane 0 is already in check.
        add(1,0,1,0,0,0,0, 2'b00,4'h0,4'b0000,0,0);
        add(0,0,1,1,0,0,0, 2'b00,4'h0,4'b0001,0,0);
        add(0,0,0,0,0,1,0, 2'b00,4'h0,4'b0011,0,0);
        add(0,1,0,0,0,0,0, 2'b00,4'h0,4'b0011,0,0);
        add(0,0,0,0,0,0,0, 2'b00,4'h0,4'b0011,0,0);
        add(0,0,0,0,0,0,0, 2'b01,4'h1,4'b0001,1,0);
        add(0,0,0,0,0,0,0, 2'b00,4'h0,4'b0001,1,0);
        add(0,0,0,0,0,0,0, 2'b01,4'h0,4'b0000,1,0);
        add(0,0,0,0,0,0,0, 2'b00,4'h0,4'b0000,1,0);
        // Test 3: four lanes flushed together; event-0 slot serialises 0,1,3.
        add(1,0,1,0,0,0,0, 2'b00,4'h0,4'b0000,0,0);
        add(0,0,1,1,0,0,0, 2'b00,4'h0,4'b0001,0,0);
        add(0,0,1,2,1,0,0, 2'b00,4'h0,4'b0011,0,0);
        add(0,0,1,3,0,0,0, 2'b00,4'h0,4'b0111,0,0);
        add(0,1,0,0,0,0,0, 2'b00,4'h0,4'b1111,0,0);
        add(0,0,0,0,0,0,0, 2'b00,4'h0,4'b1111,0,0);
        add(0,0,0,0,0,0,0, 2'b11,4'h8,4'b1010,2,0);
        add(0,0,0,0,0,0,0, 2'b01,4'h1,4'b1000,3,0);
        add(0,0,0,0,0,0,0, 2'b01,4'h3,4'b0000,4,0);
        add(0,0,0,0,0,0,0, 2'b00,4'h0,4'b0000,4,0);
        // Test 5: commit to idle lane, then alloc over a busy lane keeps event 0.
        add(1,0,0,0,0,1,1, 2'b00,4'h0,4'b0000,0,0);
        add(0,0,1,1,0,0,0, 2'b00,4'h0,4'b0000,0,1);
        add(0,0,1,1,1,0,0, 2'b00,4'h0,4'b0010,0,1);
        add(0,0,0,0,0,1,1, 2'b00,4'h0,4'b0010,0,1);
        for (int k = 0; k < 4; k++) add(0,0,0,0,0,0,0, 2'b00,4'h0,4'b0010,0,1);
        add(0,0,0,0,0,0,0, 2'b01,4'h1,4'b0000,0,1);
        add(0,0,0,0,0,0,0, 2'b00,4'h0,4'b0000,0,1);
        // Test 6: commit and flush together; then alloc during the grant cycle is illegal.
        add(1,0,1,0,1,0,0, 2'b00,4'h0,4'b0000,0,0);
        add(0,1,0,0,0,1,0, 2'b00,4'h0,4'b0001,0,0);
        for (int k = 0; k < 3; k++) add(0,0,0,0,0,0,0, 2'b00,4'h0,4'b0001,0,0);
        add(0,0,1,0,0,0,0, 2'b00,4'h0,4'b0001,0,0);
        add(0,0,0,0,0,0,0, 2'b10,4'h0,4'b0000,0,1);
        add(0,0,0,0,0,0,0, 2'b00,4'h0,4'b0000,0,1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk_i);
            if (vecs[i].rst) do_reset();
            check($sformatf("v%0d reset_valid", i), 32'(reset_valid_o),  32'(vecs[i].rv));
            check($sformatf("v%0d reset_lane", i),  32'(reset_lane_o),   32'(vecs[i].rl));
            check($sformatf("v%0d lane_busy", i),   32'(lane_busy_o),    32'(vecs[i].busy));
            check($sformatf("v%0d orphan_cnt", i),  32'(orphan_cnt_o),   32'(vecs[i].orph));
            check($sformatf("v%0d protocol_err", i),32'(protocol_err_o), 32'(vecs[i].perr));
            flush_i        = vecs[i].flush;
            alloc_valid_i  = vecs[i].av;
            alloc_lane_i   = vecs[i].al;
            alloc_event_i  = vecs[i].ae;
            commit_valid_i = vecs[i].cv;
            commit_lane_i  = vecs[i].cl;
        end

        // Test 4: lane 3 allocated at cycle 0 and never committed -> pulse at cycle 65.
        @(negedge clk_i);
        do_reset();
        alloc_valid_i = 1'b1; alloc_lane_i = 2'd3; alloc_event_i = 1'b0;
        for (int c = 1; c <= 66; c++) begin
            @(negedge clk_i);
            drive_idle();
            check($sformatf("to c%0d reset_valid", c), 32'(reset_valid_o), (c == 65) ? 32'd1 : 32'd0);
            check($sformatf("to c%0d busy3", c), 32'(lane_busy_o[3]), (c <= 64) ? 32'd1 : 32'd0);
            if (c == 65) begin
                check("to reset_lane", 32'(reset_lane_o), 32'd3);
                check("to orphan_cnt", 32'(orphan_cnt_o), 32'd1);
            end
        end

        // Test 7: asynchronous reset while lane 0 sits in check; no pulse may follow.
        @(negedge clk_i);
        do_reset();
        alloc_valid_i = 1'b1; alloc_lane_i = 2'd0; alloc_event_i = 1'b1;
        @(negedge clk_i);
        drive_idle();
        commit_valid_i = 1'b1; commit_lane_i = 2'd0;
        @(negedge clk_i);
        drive_idle();
        check("ar busy before", 32'(lane_busy_o), 32'd1);
        @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1 check("ar busy in reset", 32'(lane_busy_o), 32'd0);
        #1 rst_ni = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_i);
            check($sformatf("ar c%0d reset_valid", c), 32'(reset_valid_o), 32'd0);
            check($sformatf("ar c%0d busy", c), 32'(lane_busy_o), 32'd0);
        end
        check("ar orphan_cnt", 32'(orphan_cnt_o), 32'd0);
        check("ar protocol_err", 32'(protocol_err_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
